// File: rtl/pc_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pc_sequencer
// Description : Program counter sequencer with branch/jump/call/return,
//               exception/eret handling and a circular return-address stack.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned             WIDTH        = 32,
    parameter logic [WIDTH-1:0]        RESET_VECTOR = 'h3000,
    parameter logic [WIDTH-1:0]        EXC_VECTOR   = 'h4180,
    parameter int unsigned             RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump_en,
    input  logic             call_en,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret_en,
    input  logic             exception,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_ras_full_cnt = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_count;
    logic             r_underflow;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_epc_next;
    logic [WIDTH-1:0] w_jump_aligned;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_uf_next;

    assign w_pc_plus4     = r_pc + WIDTH'(4);
    assign w_jump_aligned = jump_target & ~WIDTH'(3);
    // Write pointer addresses the next free slot; the top sits just below it.
    assign w_ras_top      = r_ras[r_wptr - PTR_W'(1)];
    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == c_ras_full_cnt);

    always_comb begin
        w_pc_next  = w_pc_plus4;
        w_epc_next = r_epc;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_uf_next  = 1'b0;
        if (exception) begin
            w_epc_next = r_pc;
            w_pc_next  = EXC_VECTOR;
        end else if (eret) begin
            w_pc_next = r_epc;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (ret_en) begin
            if (w_empty) begin
                w_uf_next = 1'b1;
            end else begin
                w_pc_next = w_ras_top;
                w_pop     = 1'b1;
            end
        end else if (jump_en) begin
            w_pc_next = w_jump_aligned;
            w_push    = call_en;
        end else if (branch_taken) begin
            w_pc_next = r_pc + branch_offset;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc        <= RESET_VECTOR;
            r_epc       <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_epc       <= w_epc_next;
            r_underflow <= w_uf_next;
            if (w_push) begin
                // When full the write slot holds the oldest entry, so it is overwritten.
                r_wptr <= r_wptr + PTR_W'(1);
                if (!w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_wptr  <= r_wptr - PTR_W'(1);
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_ras[r_wptr] <= w_pc_plus4;
        end
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign epc           = r_epc;
    assign ras_empty     = w_empty;
    assign ras_full      = w_full;
    assign ras_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_pc_sequencer
// Description : Scoreboard bench for pc_sequencer driven by directed vectors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset, stall, branch_taken, jump_en, call_en, ret_en, exception, eret;
    logic [31:0] branch_offset, jump_target;
    logic [31:0] pc, pc_plus4, epc;
    logic        ras_empty, ras_full, ras_underflow;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        e;
        logic        f;
        logic        u;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    pc_sequencer #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h3000),
        .EXC_VECTOR   (32'h4180),
        .RAS_DEPTH    (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_en       (jump_en),
        .call_en       (call_en),
        .jump_target   (jump_target),
        .ret_en        (ret_en),
        .exception     (exception),
        .eret          (eret),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .epc           (epc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %h required %h", name, $time, act, req);
        end
    endtask

    // Monitor: every edge the DUT presents a new state; compare it to the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("pc",        pc,                    x.pc);
                chk("pc_plus4",  pc_plus4,              x.pc + 32'd4);
                chk("epc",       epc,                   x.epc);
                chk("ras_empty", {31'd0, ras_empty},     {31'd0, x.e});
                chk("ras_full",  {31'd0, ras_full},      {31'd0, x.f});
                chk("underflow", {31'd0, ras_underflow}, {31'd0, x.u});
            end
        end
    end

    // One vector: drive inputs for the next rising edge and queue the state expected after it.
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] off,
                        input logic j, input logic c, input logic [31:0] tgt, input logic rt,
                        input logic ex, input logic er,
                        input logic [31:0] e_pc, input logic [31:0] e_epc,
                        input logic e_e, input logic e_f, input logic e_u);
        exp_t x;
        reset = r; stall = s; branch_taken = b; branch_offset = off;
        jump_en = j; call_en = c; jump_target = tgt; ret_en = rt;
        exception = ex; eret = er;
        x.pc = e_pc; x.epc = e_epc; x.e = e_e; x.f = e_f; x.u = e_u;
        q.push_back(x);
        @(negedge clock);
    endtask

    task automatic idle(input logic [31:0] e_pc, input logic [31:0] e_epc, input logic e_e);
        step(0,0,0,0, 0,0,0,0, 0,0, e_pc, e_epc, e_e, 0, 0);
    endtask

    task automatic jump(input logic [31:0] tgt, input logic c, input logic [31:0] e_pc,
                        input logic [31:0] e_epc, input logic e_e, input logic e_f);
        step(0,0,0,0, 1,c,tgt,0, 0,0, e_pc, e_epc, e_e, e_f, 0);
    endtask

    task automatic ret(input logic [31:0] e_pc, input logic e_e, input logic e_u);
        step(0,0,0,0, 0,0,0,1, 0,0, e_pc, 32'h3020, e_e, 0, e_u);
    endtask

    initial begin
        int k;
        reset = 1'b1; stall = 0; branch_taken = 0; branch_offset = 0; jump_en = 0;
        call_en = 0; jump_target = 0; ret_en = 0; exception = 0; eret = 0;
        @(negedge clock);

        // Reset then idle
        step(1,0,0,0, 0,0,0,0, 0,0, 32'h3000, 0, 1, 0, 0);
        idle(32'h3004, 0, 1);
        idle(32'h3008, 0, 1);
        idle(32'h300C, 0, 1);
        idle(32'h3010, 0, 1);

        // Branch back by 8, then jump with misaligned target
        step(0,0,1,32'hFFFF_FFF8, 0,0,0,0, 0,0, 32'h3008, 0, 1, 0, 0);
        jump(32'h3403, 0, 32'h3400, 0, 1, 0);

        // Stall, exception under stall, eret
        jump(32'h3020, 0, 32'h3020, 0, 1, 0);
        step(0,1,0,0, 0,0,0,0, 0,0, 32'h3020, 0, 1, 0, 0);
        step(0,1,0,0, 0,0,0,0, 0,0, 32'h3020, 0, 1, 0, 0);
        step(0,1,0,0, 0,0,0,0, 1,0, 32'h4180, 32'h3020, 1, 0, 0);
        step(0,0,0,0, 0,0,0,0, 0,1, 32'h3020, 32'h3020, 1, 0, 0);
        idle(32'h3024, 32'h3020, 1);
        // Stalled branch/ret/call are dropped, not replayed
        step(0,1,1,32'h100, 1,1,32'h3800,1, 0,0, 32'h3024, 32'h3020, 1, 0, 0);
        idle(32'h3028, 32'h3020, 1);

        // Five calls: A=3028 B=3100 C=3200 D=3300 E=3500; the oldest is overwritten
        jump(32'h3100, 1, 32'h3100, 32'h3020, 0, 0);
        jump(32'h3200, 1, 32'h3200, 32'h3020, 0, 0);
        jump(32'h3300, 1, 32'h3300, 32'h3020, 0, 0);
        jump(32'h3500, 1, 32'h3500, 32'h3020, 0, 1);
        jump(32'h3600, 1, 32'h3600, 32'h3020, 0, 1);
        ret(32'h3504, 0, 0);
        ret(32'h3304, 0, 0);
        ret(32'h3204, 0, 0);
        ret(32'h3104, 1, 0);

        // Underflow at 3100
        jump(32'h3100, 0, 32'h3100, 32'h3020, 1, 0);
        ret(32'h3104, 1, 1);
        idle(32'h3108, 32'h3020, 1);

        // ret wins over jump+call with RAS top 3200
        jump(32'h31FC, 0, 32'h31FC, 32'h3020, 1, 0);
        jump(32'h3700, 1, 32'h3700, 32'h3020, 0, 0);
        step(0,0,0,0, 1,1,32'h3800,1, 0,0, 32'h3200, 32'h3020, 1, 0, 0);
        // call_en alone is ignored
        step(0,0,0,0, 0,1,32'h3800,0, 0,0, 32'h3204, 32'h3020, 1, 0, 0);

        // Sequential wrap at the top of the address space
        jump(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h3020, 1, 0);
        idle(32'h0000_0000, 32'h3020, 1);

        // Reset mid-operation with exception, stall and ret pending
        jump(32'h3300, 1, 32'h3300, 32'h3020, 0, 0);
        step(1,1,0,0, 0,0,0,1, 1,0, 32'h3000, 0, 1, 0, 0);
        idle(32'h3004, 0, 1);

        reset = 0; stall = 0; branch_taken = 0; jump_en = 0; call_en = 0;
        ret_en = 0; exception = 0; eret = 0;
        k = 0;
        while (q.size() > 0 && k < 10) begin
            @(negedge clock);
            k++;
        end
        if (q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        done = 1'b1;
    end

    initial begin
        wait (done);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the PC and address width in bits (minimum 8).
REQ-002 The block SHALL have parameter RESET_VECTOR, default 'h3000, giving the PC value loaded on reset.
REQ-003 The block SHALL have parameter EXC_VECTOR, default 'h4180, giving the PC value loaded on exception.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4, giving the number of return-address stack entries (power of two, minimum 2).
REQ-005 The block SHALL have these ports:
- clock  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC
- branch_taken  in  1  relative redirect
- branch_offset  in  WIDTH  signed byte offset, already sign-extended
- jump_en  in  1  absolute redirect
- call_en  in  1  absolute redirect plus RAS push; qualified by jump_en
- jump_target  in  WIDTH  absolute target
- ret_en  in  1  redirect to RAS top plus pop
- exception  in  1  trap request
- eret  in  1  return from trap
- pc  out  WIDTH  current PC (registered)
- pc_plus4  out  WIDTH  pc+4 (combinational)
- epc  out  WIDTH  PC captured at the last exception (registered)
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_underflow  out  1  one-cycle pulse on a pop from an empty RAS

Function
REQ-006 The block SHALL select next PC by fixed priority: reset > exception > eret > stall > ret_en > jump_en > branch_taken > sequential.
REQ-007 Sequential advance SHALL be pc <= pc+4, computed modulo 2^WIDTH, so 'hFFFF_FFFC wraps to 0.
REQ-008 A taken branch SHALL load pc <= pc + branch_offset, modulo 2^WIDTH.
REQ-009 jump_en SHALL load pc <= jump_target with bits [1:0] forced to 0.
REQ-010 jump_en with call_en SHALL also push pc+4 onto the RAS in the same cycle.
REQ-011 call_en without jump_en SHALL be ignored.
REQ-012 ret_en with a non-empty RAS SHALL load pc <= RAS top entry and pop that entry in the same cycle.
REQ-013 ret_en with an empty RAS SHALL do all of the following:
- load pc <= pc+4
- leave the RAS unchanged
- assert ras_underflow for exactly the next cycle
REQ-014 A push when the RAS is full SHALL overwrite the oldest entry (circular buffer), keep the count at RAS_DEPTH, and raise no flag.
REQ-015 When ret_en and jump_en/call_en are both asserted, ret_en SHALL win, and the block SHALL neither push nor jump.
REQ-016 exception SHALL act even when stall is asserted, and SHALL do all of the following:
- load epc <= pc
- load pc <= EXC_VECTOR
- leave the RAS unchanged
REQ-017 eret (without exception) SHALL load pc <= epc, even when stall is asserted.
REQ-018 stall (without exception or eret) SHALL hold pc, epc and the RAS unchanged.
REQ-019 Under stall, ret_en, call_en and branch_taken SHALL be discarded, not queued.
REQ-020 ras_empty and ras_full SHALL be derived from a registered entry count, 0..RAS_DEPTH.
REQ-021 The block SHALL update every output exactly once per rising edge.

Reset
REQ-022 On a rising edge with reset high, the block SHALL set:
- pc = RESET_VECTOR
- epc = 0
- RAS count = 0 (ras_empty = 1, ras_full = 0)
- ras_underflow = 0
REQ-023 On a reset edge, all other inputs SHALL be ignored, including exception.
REQ-024 Reset asserted mid-operation SHALL discard stall, the RAS contents and any pending redirect.
REQ-025 The RAS entry storage SHALL NOT require reset.

Verification
REQ-026 Reset then idle: 3 cycles -> pc = 'h3000, 'h3004, 'h3008; ras_empty = 1.
REQ-027 Branch, then jump:
- at pc = 'h3010, branch_taken with offset -8 -> pc = 'h3008
- then jump_en with target 'h3403 -> pc = 'h3400
REQ-028 Stall and exception:
- stall for 2 cycles at 'h3020 -> pc holds 'h3020
- then exception with stall still high -> pc = 'h4180, epc = 'h3020
- then eret -> pc = 'h3020
REQ-029 RAS overflow (RAS_DEPTH = 4):
- 5 calls from pc values A..E -> ras_full = 1
- then 4 rets -> pc = E+4, D+4, C+4, B+4 in that order
- after those rets -> ras_empty = 1
REQ-030 RAS underflow: ret_en with empty RAS at pc = 'h3100 -> pc = 'h3104 and ras_underflow = 1 for exactly 1 cycle.
REQ-031 Conflicts:
- ret_en with jump_en and call_en, RAS top 'h3200 -> pc = 'h3200 and RAS count decrements by 1
- reset asserted with exception -> pc = 'h3000, epc = 0
